riscv_run_monitor: RTL and testbench

- Synthesizable run-supervision block that sits beside `top` in simulation and FPGA builds.
- Snoops the data-memory write bus and the PC, and counts executed cycles.
- Decides the program outcome: PASS on a write of the expected value to the signature address, FAIL on a write of any other value there, HANG on a self-loop at a stable PC, TIMEOUT when the cycle budget is exhausted.
- Replaces fixed-delay end-of-run dumps with a parametrised, sticky verdict and counters.

---
 rtl/riscv_run_monitor.sv | 131 +++++++++++++
 tb/tb_riscv_run_monitor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_run_monitor.sv
// rtl/riscv_run_monitor.sv - run supervisor: PASS/FAIL/HANG/TIMEOUT verdict, cycle and store counters
// Optional store trace enabled by defining RUN_MONITOR_STORE_TRACE_EN.
module riscv_run_monitor #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] SIG_ADDR    = 32'd100,
  parameter logic [XLEN-1:0] PASS_DATA   = 32'd25,
  parameter int              MAX_CYCLES  = 1000,
  parameter int              HANG_CYCLES = 4,
  parameter int              CNT_W       = 32,
  parameter int              TRACE_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           mem_write,
  input  logic [XLEN-1:0]                data_addr,
  input  logic [XLEN-1:0]                wr_data,
  input  logic [XLEN-1:0]                pc,
  output logic                           done,
  output logic [2:0]                     status,
  output logic [CNT_W-1:0]               cycle_count,
  output logic [CNT_W-1:0]               store_count
`ifdef RUN_MONITOR_STORE_TRACE_EN
  ,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [XLEN-1:0]                trace_addr,
  output logic [XLEN-1:0]                trace_data,
  output logic                           trace_valid
`endif
);

  localparam int HW = $clog2(HANG_CYCLES + 1);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_PASS    = 3'd1,
    S_FAIL    = 3'd2,
    S_HANG    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [HW-1:0]   hang_cnt;
  logic [XLEN-1:0] last_pc;
  logic            sig_hit;
  logic            pc_rep;
  logic            in_run;

  assign sig_hit = mem_write && (data_addr == SIG_ADDR);
  assign pc_rep  = (pc == last_pc);
  assign in_run  = (state == S_RUN);
  assign status  = state;
  assign done    = !in_run;

  // Verdict register; terminal states hold until reset.
  always_ff @(posedge clk) begin
    if (reset) state <= S_RUN;
    else       state <= state_nxt;
  end

  // Verdict selection from RUN, signature store first, then hang, then budget.
  always_comb begin
    state_nxt = state;
    if (in_run) begin
      if (sig_hit && (wr_data == PASS_DATA))
        state_nxt = S_PASS;
      else if (sig_hit)
        state_nxt = S_FAIL;
      else if ((hang_cnt == HW'(HANG_CYCLES - 1)) && pc_rep)
        state_nxt = S_HANG;
      else if (cycle_count == CNT_W'(MAX_CYCLES - 1))
        state_nxt = S_TIMEOUT;
    end
  end

  // Saturating counters and pc-repeat tracking; all frozen once a verdict exists.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
      store_count <= '0;
      hang_cnt    <= '0;
      last_pc     <= '0;
    end else if (in_run) begin
      if (cycle_count != '1)
        cycle_count <= cycle_count + 1'b1;
      if (mem_write && (store_count != '1))
        store_count <= store_count + 1'b1;
      last_pc <= pc;
      if (!pc_rep)
        hang_cnt <= '0;
      else if (hang_cnt != HW'(HANG_CYCLES))
        hang_cnt <= hang_cnt + 1'b1;
    end
  end

`ifdef RUN_MONITOR_STORE_TRACE_EN
  localparam int TW = $clog2(TRACE_DEPTH);

  logic [XLEN-1:0] tr_addr [TRACE_DEPTH];
  logic [XLEN-1:0] tr_data [TRACE_DEPTH];
  logic [TW-1:0]   wptr;
  logic [TW:0]     fill;
  logic [TW-1:0]   rd_ptr;

  // Trace entries carry no reset; validity is tracked by the fill count.
  always_ff @(posedge clk) begin
    if (in_run && mem_write && !reset) begin
      tr_addr[wptr] <= data_addr;
      tr_data[wptr] <= wr_data;
    end
  end

  // Write pointer wraps naturally; fill count saturates at the depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      fill <= '0;
    end else if (in_run && mem_write) begin
      wptr <= wptr + 1'b1;
      if (fill != (TW + 1)'(TRACE_DEPTH))
        fill <= fill + 1'b1;
    end
  end

  // Index 0 is the most recent store.
  assign rd_ptr      = wptr - 1'b1 - trace_idx;
  assign trace_addr  = tr_addr[rd_ptr];
  assign trace_data  = tr_data[rd_ptr];
  assign trace_valid = ({1'b0, trace_idx} < fill);
`endif

endmodule

// File: tb/tb_riscv_run_monitor.sv
// tb/tb_riscv_run_monitor.sv - randomized and directed bench for riscv_run_monitor against a behavioural model
module tb_riscv_run_monitor;

  localparam int          MAXC  = 20;
  localparam int          HANGC = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] SIG   = 32'd100;
  localparam logic [31:0] PASSD = 32'd25;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_write = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] pc = '0;
  logic        done;
  logic [2:0]  status;
  logic [31:0] cycle_count;
  logic [31:0] store_count;
`ifdef RUN_MONITOR_STORE_TRACE_EN
  logic [2:0]  trace_idx = '0;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        trace_valid;
`endif

  int checks = 0;
  int errors = 0;

  // Model: verdict, counts, run of consecutive repeated pcs, and store history (newest first).
  int          m_status;
  int          m_cycles;
  int          m_stores;
  int          m_run;
  logic [31:0] m_last_pc;
  logic [63:0] m_trace[$];

  riscv_run_monitor #(
    .MAX_CYCLES (MAXC),
    .HANG_CYCLES(HANGC),
    .TRACE_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_write  (mem_write),
    .data_addr  (data_addr),
    .wr_data    (wr_data),
    .pc         (pc),
    .done       (done),
    .status     (status),
    .cycle_count(cycle_count),
    .store_count(store_count)
`ifdef RUN_MONITOR_STORE_TRACE_EN
    ,
    .trace_idx  (trace_idx),
    .trace_addr (trace_addr),
    .trace_data (trace_data),
    .trace_valid(trace_valid)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_status  = 0;
    m_cycles  = 0;
    m_stores  = 0;
    m_run     = 0;
    m_last_pc = '0;
    m_trace.delete();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_write = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Apply one cycle of inputs, advance the model by the verdict rules, sample after the edge.
  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    mem_write = mw; data_addr = a; wr_data = d; pc = p;
    if (m_status == 0) begin
      m_run = (p == m_last_pc) ? m_run + 1 : 0;
      if (mw && a == SIG)      m_status = (d == PASSD) ? 1 : 2;
      else if (m_run >= HANGC) m_status = 3;
      else if (m_cycles + 1 == MAXC) m_status = 4;
      m_cycles++;
      if (mw) begin
        m_stores++;
        m_trace.push_front({a, d});
      end
      m_last_pc = p;
    end
    @(posedge clk); #1;
    mem_write = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (status !== 3'd0) begin errors++; $display("FAIL reset_status: got %0d want 0", status); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cycles: got %0d want 0", cycle_count); end
    checks++; if (store_count !== 32'd0) begin errors++; $display("FAIL reset_stores: got %0d want 0", store_count); end
    for (int k = 1; k <= 3; k++) step(1'b1, 32'd80, 32'd1, 32'h200 + 32'(4 * k));
    do_reset();
    checks++; if ({done, status, cycle_count, store_count} !== 68'd0) begin errors++; $display("FAIL reset_midrun: got done=%0b status=%0d cyc=%0d st=%0d want all 0", done, status, cycle_count, store_count); end
  endtask

  task automatic test_pass();
    do_reset();
    for (int k = 1; k <= 11; k++)
      step(k == 3 || k == 5, (k == 3) ? 32'd80 : 32'd84, (k == 3) ? 32'd7 : 32'd9, 32'h100 + 32'(4 * k));
    checks++; if (status !== 3'd0 || done !== 1'b0) begin errors++; $display("FAIL pass_pre: got status=%0d done=%0b want 0/0", status, done); end
    step(1'b1, SIG, PASSD, 32'h130);
    checks++; if (status !== 3'd1 || done !== 1'b1) begin errors++; $display("FAIL pass_status: got status=%0d done=%0b want 1/1", status, done); end
    checks++; if (store_count !== 32'd3) begin errors++; $display("FAIL pass_stores: got %0d want 3", store_count); end
    checks++; if (cycle_count !== 32'd12) begin errors++; $display("FAIL pass_cycles: got %0d want 12", cycle_count); end
    for (int k = 0; k < 5; k++) step(1'b1, (k == 2) ? SIG : 32'd88, 32'd24, 32'h134);
    checks++; if (status !== 3'd1 || cycle_count !== 32'd12 || store_count !== 32'd3) begin errors++; $display("FAIL pass_frozen: got status=%0d cyc=%0d st=%0d want 1/12/3", status, cycle_count, store_count); end
  endtask

  task automatic test_fail();
    do_reset();
    step(1'b0, 32'd0, 32'd0, 32'h10);
    step(1'b1, SIG, 32'd24, 32'h14);
    checks++; if (status !== 3'd2 || done !== 1'b1) begin errors++; $display("FAIL fail_status: got status=%0d done=%0b want 2/1", status, done); end
    step(1'b1, SIG, PASSD, 32'h18);
    checks++; if (status !== 3'd2) begin errors++; $display("FAIL fail_sticky: got %0d want 2", status); end
  endtask

  task automatic test_hang();
    do_reset();
    for (int k = 12; k <= 17; k++) step(1'b0, 32'd0, 32'd0, 32'(4 * k));
    for (int r = 1; r <= 3; r++) begin
      step(1'b0, 32'd0, 32'd0, 32'h44);
      checks++; if (status !== 3'd0) begin errors++; $display("FAIL hang_early_r%0d: got %0d want 0", r, status); end
    end
    step(1'b0, 32'd0, 32'd0, 32'h44);
    checks++; if (status !== 3'd3 || done !== 1'b1) begin errors++; $display("FAIL hang_status: got status=%0d done=%0b want 3/1", status, done); end
  endtask

  task automatic test_no_hang();
    do_reset();
    step(1'b0, 32'd0, 32'd0, 32'h40);
    for (int r = 0; r < 3; r++) step(1'b0, 32'd0, 32'd0, 32'h40);
    step(1'b0, 32'd0, 32'd0, 32'h44);
    for (int r = 0; r < 3; r++) step(1'b0, 32'd0, 32'd0, 32'h44);
    step(1'b0, 32'd0, 32'd0, 32'h48);
    checks++; if (status !== 3'd0 || done !== 1'b0) begin errors++; $display("FAIL no_hang: got status=%0d done=%0b want 0/0", status, done); end
  endtask

  task automatic test_timeout(input bit sig_last);
    do_reset();
    for (int k = 1; k < MAXC; k++) step(1'b0, 32'd0, 32'd0, 32'(8 * k));
    checks++; if (status !== 3'd0) begin errors++; $display("FAIL timeout_pre: got %0d want 0", status); end
    step(sig_last, SIG, PASSD, 32'h400);
    if (sig_last) begin
      checks++; if (status !== 3'd1) begin errors++; $display("FAIL timeout_sig_last: got %0d want 1", status); end
    end else begin
      checks++; if (status !== 3'd4 || done !== 1'b1) begin errors++; $display("FAIL timeout_status: got status=%0d done=%0b want 4/1", status, done); end
      checks++; if (cycle_count !== 32'(MAXC)) begin errors++; $display("FAIL timeout_cycles: got %0d want %0d", cycle_count, MAXC); end
    end
  endtask

  task automatic test_reset_after_pass();
    do_reset();
    step(1'b1, SIG, PASSD, 32'h20);
    do_reset();
    checks++; if ({done, status, cycle_count, store_count} !== 68'd0) begin errors++; $display("FAIL rerun_reset: got done=%0b status=%0d cyc=%0d st=%0d want all 0", done, status, cycle_count, store_count); end
    step(1'b1, 32'd80, 32'd5, 32'h20);
    step(1'b0, 32'd0, 32'd0, 32'h24);
    checks++; if (status !== 3'd0 || cycle_count !== 32'd2 || store_count !== 32'd1) begin errors++; $display("FAIL rerun_progress: got status=%0d cyc=%0d st=%0d want 0/2/1", status, cycle_count, store_count); end
    step(1'b1, SIG, 32'd3, 32'h28);
    checks++; if (status !== 3'd2) begin errors++; $display("FAIL rerun_fail: got %0d want 2", status); end
  endtask

  task automatic test_random();
    logic [31:0] p, a, d;
    logic        mw;
    for (int run = 0; run < 30; run++) begin
      do_reset();
      p = 32'(4 * $urandom_range(0, 15));
      for (int c = 0; c < MAXC + 4; c++) begin
        if ($urandom_range(0, 9) >= 4) p = 32'(4 * $urandom_range(0, 15));
        mw = ($urandom_range(0, 9) < 4);
        a  = ($urandom_range(0, 19) == 0) ? SIG : 32'(80 + 4 * $urandom_range(0, 3));
        d  = ($urandom_range(0, 1) == 1) ? PASSD : 32'($urandom_range(0, 50));
        step(mw, a, d, p);
        checks++;
        if (status !== 3'(m_status) || done !== (m_status != 0) || cycle_count !== 32'(m_cycles) || store_count !== 32'(m_stores)) begin
          errors++;
          $display("FAIL random_r%0d_c%0d: got status=%0d done=%0b cyc=%0d st=%0d want %0d/%0b/%0d/%0d",
                   run, c, status, done, cycle_count, store_count, m_status, m_status != 0, m_cycles, m_stores);
        end
      end
`ifdef RUN_MONITOR_STORE_TRACE_EN
      for (int i = 0; i < DEPTH; i++) begin
        trace_idx = 3'(i); #1;
        checks++;
        if (trace_valid !== (i < m_trace.size())) begin
          errors++; $display("FAIL random_trace_valid_r%0d_i%0d: got %0b want %0b", run, i, trace_valid, i < m_trace.size());
        end else if (i < m_trace.size() && {trace_addr, trace_data} !== m_trace[i]) begin
          errors++; $display("FAIL random_trace_r%0d_i%0d: got %h/%h want %h", run, i, trace_addr, trace_data, m_trace[i]);
        end
      end
`endif
    end
  endtask

`ifdef RUN_MONITOR_STORE_TRACE_EN
  task automatic test_trace();
    do_reset();
    for (int k = 1; k <= 10; k++) step(1'b1, 32'(200 + 4 * k), 32'(k), 32'(8 * k));
    for (int i = 0; i < DEPTH; i++) begin
      trace_idx = 3'(i); #1;
      checks++;
      if (trace_valid !== 1'b1 || trace_data !== 32'(10 - i) || trace_addr !== 32'(200 + 4 * (10 - i))) begin
        errors++; $display("FAIL trace_i%0d: got v=%0b data=%0d addr=%0d want 1/%0d/%0d", i, trace_valid, trace_data, trace_addr, 10 - i, 200 + 4 * (10 - i));
      end
    end
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      trace_idx = 3'(i); #1;
      checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL trace_reset_i%0d: got %0b want 0", i, trace_valid); end
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_pass();
    test_fail();
    test_hang();
    test_no_hang();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_after_pass();
`ifdef RUN_MONITOR_STORE_TRACE_EN
    test_trace();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
